master_port: RTL and testbench
==============================

// Module: master_port
// PURPOSE
//  Initiator end of the single-wire-per-direction serial bus; drives slave rx and samples slave tx.
//  Accepts one read/write command from the local user, requests the slave, waits out SPLIT,
//  then shifts 12 address bits, a mode bit and 8 data bits. Reads capture 8 returned bits.
//  Sits between the local master logic and the bus lines to slave1.
// PARAMETERS
//  ADDR_W          12    address bits serialised, LSB first
//  DATA_W          8     data bits per transfer, LSB first
//  TIMEOUT_CYCLES  1024  max cycles in REQ before abort (REQ_TIMEOUT_EN only)
// PORTS
//  clk        in   1       clock, all logic on posedge
//  rstn       in   1       asynchronous active-low reset
//  start      in   1       command strobe, accepted only when ready=1
//  wr         in   1       1=write, 0=read; sampled with start
//  addr       in   ADDR_W  target address; sampled with start
//  wdata      in   DATA_W  write data; sampled with start
//  ready      out  1       idle, can accept start
//  rdata      out  DATA_W  read data, held until next read completes
//  done       out  1       one-cycle pulse, transaction complete
//  mtx        out  1       serial line to slave rx, idle high
//  mrx        in   1       serial line from slave tx, idle high
//  state_o    out  4       current FSM state (debug)
//  timeout    out  1       one-cycle abort pulse (REQ_TIMEOUT_EN only)
// BEHAVIOUR
//  Reset: mtx=1, ready=1, done=0, rdata=0, timeout=0, state=IDLE, command regs cleared.
//  All outputs registered. start while ready=0 ignored. Command latched on accepting edge.
//  IDLE(0): ready=1. start -> mtx<=0, ready<=0, REQ. Edge R = accepting edge.
//  REQ(1): hold mtx=0, never released while waiting (slave SPLIT requires rx low).
//   Grant edge G = first edge sampling mrx==0 in REQ. Unbusy slave: G=R+3.
//   After SPLIT: G tracks slave, 1 cycle after busy falls. Go SETUP at G.
//  SETUP(2): mtx=0 through edges G+1, G+2.
//  ADDR(3): mtx<=addr[i] at edge G+3+i, i=0..11.
//  MODE(4): mtx<=wr at G+15 (1=write, 0=read).
//  WDATA(5): mtx<=wdata[j] at G+16+j, j=0..7; mtx<=1 at G+24.
//  RWAIT(6): read only. mtx<=1 at G+16; edges G+16, G+17 idle.
//  RDATA(7): shift reg bit j <= mrx at G+18+j, j=0..7; rdata updated at G+25.
//  DONE(8): entered at G+25 both modes; done=1 for that one cycle; ready<=1; IDLE at G+26.
//   Next start earliest G+26 (slave back in IDLE); back-to-back supported.
//  Counter: 5 bits, cleared on every state change; unused state codes -> IDLE, mtx<=1.
//  mrx ignored outside REQ and RDATA. mrx high mid-RDATA: sampled as-is, no error check.
//  rstn low mid-transfer: immediate return to reset values; slave shares rstn, no resync.
//  Write rdata unchanged. done and start same cycle: start ignored (ready still 0).
// CONFIGURATION
//  REQ_TIMEOUT_EN defined: REQ counts cycles. After TIMEOUT_CYCLES without grant:
//   mtx<=1, timeout pulses 1 cycle, no done, ready<=1, IDLE.
//   A slave left in SPLIT resumes on the next request; grant detection adapts.
//  Undefined: REQ waits indefinitely; timeout port absent.
// TESTING
//  Write addr=0xA5C wdata=0x3E, busy=0 -> G=R+3; mtx bits per schedule; slave wdata=0x3E; done at G+25.
//  Read addr=0x123, slave rdata=0xD3 -> rdata=0xD3 at G+25; done 1 cycle; mtx high from G+16.
//  busy=1 for 10 cycles after request -> mtx stays 0; G 1 cycle after busy falls; write 0x5A completes.
//  Back-to-back: write 0x11, start at G+26 read -> slave re-granted; rdata=0xD3; no lost/extra bits.
//  rstn low at G+8 -> mtx=1, ready=1, done=0 asynchronously; next write 0x77 after reset succeeds.
//  REQ_TIMEOUT_EN, TIMEOUT_CYCLES=16, busy stuck 1 -> timeout pulse 16 cycles after entering REQ; mtx=1; ready=1.

Source files
------------

// File: rtl/master_port.sv
// Initiator side of the serial bus: request/grant with SPLIT wait, then address, mode and data shifting.
// Optional REQ_TIMEOUT_EN macro adds an abort (timeout pulse) when the grant never arrives.
module master_port #(
   parameter int unsigned ADDR_W = 12,
   parameter int unsigned DATA_W = 8
`ifdef REQ_TIMEOUT_EN
   , parameter int unsigned TIMEOUT_CYCLES = 1024
`endif
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              start,
   input  logic              wr,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic              ready,
   output logic [DATA_W-1:0] rdata,
   output logic              done,
   output logic              mtx,
   input  logic              mrx,
   output logic [3:0]        state_o
`ifdef REQ_TIMEOUT_EN
   , output logic            timeout
`endif
);

   localparam int unsigned CNT_W     = 5;
   localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_W - 1);
   localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
   localparam logic [CNT_W-1:0] WR_END    = CNT_W'(DATA_W + 1);

   typedef enum logic [3:0] {
      S_IDLE  = 4'd0,
      S_REQ   = 4'd1,
      S_SETUP = 4'd2,
      S_ADDR  = 4'd3,
      S_MODE  = 4'd4,
      S_WDATA = 4'd5,
      S_RWAIT = 4'd6,
      S_RDATA = 4'd7,
      S_DONE  = 4'd8
   } state_t;

   state_t             state_q;
   logic [CNT_W-1:0]   cnt_q;
   logic               wr_q;
   logic [ADDR_W-1:0]  addr_q;
   logic [DATA_W-1:0]  wdata_q;
   logic [DATA_W-1:0]  shift_q;
   logic [DATA_W-1:0]  rdata_q;
   logic               ready_q;
   logic               done_q;
   logic               mtx_q;

`ifdef REQ_TIMEOUT_EN
   localparam int unsigned TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
   logic [TMO_W-1:0]   tmo_q;
   logic               timeout_q;
   assign timeout = timeout_q;
`endif

   assign ready   = ready_q;
   assign rdata   = rdata_q;
   assign done    = done_q;
   assign mtx     = mtx_q;
   assign state_o = state_q;

   // Transaction sequencer; address and write data are consumed LSB first by right shifts.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         wr_q      <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         shift_q   <= '0;
         rdata_q   <= '0;
         ready_q   <= 1'b1;
         done_q    <= 1'b0;
         mtx_q     <= 1'b1;
`ifdef REQ_TIMEOUT_EN
         tmo_q     <= '0;
         timeout_q <= 1'b0;
`endif
      end else begin
         done_q <= 1'b0;
`ifdef REQ_TIMEOUT_EN
         timeout_q <= 1'b0;
`endif
         case (state_q)
            S_IDLE: begin
               mtx_q   <= 1'b1;
               ready_q <= 1'b1;
               if (start && ready_q) begin
                  state_q <= S_REQ;
                  mtx_q   <= 1'b0;
                  ready_q <= 1'b0;
                  wr_q    <= wr;
                  addr_q  <= addr;
                  wdata_q <= wdata;
                  cnt_q   <= '0;
`ifdef REQ_TIMEOUT_EN
                  tmo_q   <= '0;
`endif
               end
            end
            // Line held low throughout: a split slave only resumes while rx stays low.
            S_REQ: begin
               mtx_q <= 1'b0;
               if (!mrx) begin
                  state_q <= S_SETUP;
                  cnt_q   <= '0;
               end
`ifdef REQ_TIMEOUT_EN
               else if (tmo_q == TMO_LAST) begin
                  state_q   <= S_IDLE;
                  mtx_q     <= 1'b1;
                  ready_q   <= 1'b1;
                  timeout_q <= 1'b1;
                  cnt_q     <= '0;
               end else begin
                  tmo_q <= tmo_q + TMO_W'(1);
               end
`endif
            end
            S_SETUP: begin
               mtx_q <= 1'b0;
               if (cnt_q == CNT_W'(1)) begin
                  state_q <= S_ADDR;
                  cnt_q   <= '0;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            S_ADDR: begin
               mtx_q  <= addr_q[0];
               addr_q <= addr_q >> 1;
               if (cnt_q == ADDR_LAST) begin
                  state_q <= S_MODE;
                  cnt_q   <= '0;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            S_MODE: begin
               mtx_q   <= wr_q;
               state_q <= wr_q ? S_WDATA : S_RWAIT;
               cnt_q   <= '0;
            end
            // Data bits, then the line returns high for two cycles before completion.
            S_WDATA: begin
               if (cnt_q <= DATA_LAST) begin
                  mtx_q   <= wdata_q[0];
                  wdata_q <= wdata_q >> 1;
               end else begin
                  mtx_q <= 1'b1;
               end
               if (cnt_q == WR_END) begin
                  state_q <= S_DONE;
                  done_q  <= 1'b1;
                  cnt_q   <= '0;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            S_RWAIT: begin
               mtx_q <= 1'b1;
               if (cnt_q == CNT_W'(1)) begin
                  state_q <= S_RDATA;
                  cnt_q   <= '0;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            S_RDATA: begin
               mtx_q   <= 1'b1;
               shift_q <= {mrx, shift_q[DATA_W-1:1]};
               if (cnt_q == DATA_LAST) begin
                  rdata_q <= {mrx, shift_q[DATA_W-1:1]};
                  state_q <= S_DONE;
                  done_q  <= 1'b1;
                  cnt_q   <= '0;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            S_DONE: begin
               mtx_q   <= 1'b1;
               ready_q <= 1'b1;
               state_q <= S_IDLE;
               cnt_q   <= '0;
            end
            default: begin
               state_q <= S_IDLE;
               mtx_q   <= 1'b1;
               ready_q <= 1'b1;
               cnt_q   <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_master_port.sv
// Directed bench for master_port: the bench plays the slave, decodes the serial stream
// and checks timing of grant, shift phases, done pulse and reset.
module tb_master_port;

   logic        clk;
   logic        rstn;
   logic        start;
   logic        wr;
   logic [11:0] addr;
   logic [7:0]  wdata;
   logic        ready;
   logic [7:0]  rdata;
   logic        done;
   logic        mtx;
   logic        mrx;
   logic [3:0]  state_o;
`ifdef REQ_TIMEOUT_EN
   logic        timeout;
`endif

   int n_cmp;
   int n_bad;

   master_port dut (
      .clk     (clk),
      .rstn    (rstn),
      .start   (start),
      .wr      (wr),
      .addr    (addr),
      .wdata   (wdata),
      .ready   (ready),
      .rdata   (rdata),
      .done    (done),
      .mtx     (mtx),
      .mrx     (mrx),
      .state_o (state_o)
`ifdef REQ_TIMEOUT_EN
      , .timeout (timeout)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   // One full transaction; busy = extra cycles the slave withholds the grant.
   task automatic xact(input logic w, input logic [11:0] a, input logic [7:0] wd,
                       input int busy, input logic [7:0] srd, input logic [7:0] exp_rd,
                       input logic noise);
      logic [11:0] cap_a;
      logic [7:0]  cap_d;
      logic        cap_m;
      logic        hold_ok;
      logic        setup_ok;
      logic        high_ok;
      logic        early_done;
      cap_a = '0; cap_d = '0; cap_m = 1'b0;
      hold_ok = 1'b1; setup_ok = 1'b1; high_ok = 1'b1; early_done = 1'b0;

      @(negedge clk);
      start = 1'b1; wr = w; addr = a; wdata = wd;
      @(posedge clk); #1;
      start = 1'b0;
      check_eq("req_state", 32'(state_o), 1);
      check_eq("req_mtx", 32'(mtx), 0);
      check_eq("req_ready", 32'(ready), 0);
      if (noise) begin
         start = 1'b1; wr = ~w; addr = ~a; wdata = ~wd;
      end
      for (int k = 0; k < 2 + busy; k++) begin
         @(posedge clk); #1;
         if (mtx !== 1'b0 || state_o !== 4'd1) hold_ok = 1'b0;
      end
      check_eq("req_hold", 32'(hold_ok), 1);
      mrx = 1'b0;
      @(posedge clk); #1;
      mrx = 1'b1;
      start = 1'b0;
      check_eq("grant_state", 32'(state_o), 2);

      for (int e = 1; e <= 25; e++) begin
         mrx = (!w && e >= 18) ? srd[e-18] : 1'b1;
         @(posedge clk); #1;
         if (done !== 1'b0 && e < 25) early_done = 1'b1;
         if (e <= 2) begin
            if (mtx !== 1'b0) setup_ok = 1'b0;
         end else if (e <= 14) begin
            cap_a[e-3] = mtx;
         end else if (e == 15) begin
            cap_m = mtx;
         end else if (w && e <= 23) begin
            cap_d[e-16] = mtx;
         end else begin
            if (mtx !== 1'b1) high_ok = 1'b0;
         end
      end
      mrx = 1'b1;
      check_eq("setup_low", 32'(setup_ok), 1);
      check_eq("addr_bits", 32'(cap_a), 32'(a));
      check_eq("mode_bit", 32'(cap_m), 32'(w));
      if (w) check_eq("wdata_bits", 32'(cap_d), 32'(wd));
      check_eq("tail_high", 32'(high_ok), 1);
      check_eq("no_early_done", 32'(early_done), 0);
      check_eq("done_pulse", 32'(done), 1);
      check_eq("done_state", 32'(state_o), 8);
      check_eq("done_ready", 32'(ready), 0);
      check_eq("rdata", 32'(rdata), 32'(exp_rd));
      if (noise) start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      check_eq("done_clear", 32'(done), 0);
      check_eq("idle_ready", 32'(ready), 1);
      check_eq("idle_state", 32'(state_o), 0);
      check_eq("idle_mtx", 32'(mtx), 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      n_cmp = 0; n_bad = 0;
      rstn = 1'b0; start = 1'b0; wr = 1'b0; addr = '0; wdata = '0; mrx = 1'b1;
      #12;
      check_eq("rst_mtx", 32'(mtx), 1);
      check_eq("rst_ready", 32'(ready), 1);
      check_eq("rst_done", 32'(done), 0);
      check_eq("rst_rdata", 32'(rdata), 0);
      check_eq("rst_state", 32'(state_o), 0);
      @(negedge clk); rstn = 1'b1;
      @(negedge clk);

      xact(1'b1, 12'hA5C, 8'h3E, 0, 8'h00, 8'h00, 1'b0);
      xact(1'b0, 12'h123, 8'h00, 0, 8'hD3, 8'hD3, 1'b0);
      xact(1'b1, 12'h6E1, 8'h5A, 10, 8'h00, 8'hD3, 1'b1);
      xact(1'b0, 12'h0FF, 8'h00, 2, 8'h4B, 8'h4B, 1'b1);
      xact(1'b1, 12'h011, 8'h11, 0, 8'h00, 8'h4B, 1'b0);
      xact(1'b0, 12'hFFF, 8'h00, 0, 8'hD3, 8'hD3, 1'b0);

      // Asynchronous reset in the middle of the address phase.
      @(negedge clk);
      start = 1'b1; wr = 1'b1; addr = 12'h3C1; wdata = 8'hF0;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (2) begin @(posedge clk); #1; end
      mrx = 1'b0;
      @(posedge clk); #1;
      mrx = 1'b1;
      repeat (8) begin @(posedge clk); #1; end
      check_eq("pre_rst_state", 32'(state_o), 3);
      check_eq("pre_rst_mtx", 32'(mtx), 0);
      #1 rstn = 1'b0;
      #1;
      check_eq("arst_mtx", 32'(mtx), 1);
      check_eq("arst_ready", 32'(ready), 1);
      check_eq("arst_done", 32'(done), 0);
      check_eq("arst_state", 32'(state_o), 0);
      check_eq("arst_rdata", 32'(rdata), 0);
      @(negedge clk); rstn = 1'b1;
      @(negedge clk);

      xact(1'b1, 12'h555, 8'h77, 0, 8'h00, 8'h00, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
